// File: rtl/power_spec_accum_if.sv
// power_spec_accum_if
//   Bundles the FFT-side input stream and the spectrum capture stream of
//   power_spec_accum into one interface.
//   slave  : the accumulator block (consumes FFT samples and control, drives results)
//   master : whoever feeds the block and captures its output (FFT wrapper, bench)
//   Control : start_i, accum_num_i
//   FFT in  : fft_re_i, fft_im_i, xk_index_i, dv_i
//   Out     : out_data_o, out_index_o, out_valid_o, out_last_o
//   Status  : busy_o, done_o, overrun_o, frame_cnt_o
interface power_spec_accum_if #(
    parameter int NofBits = 16,
    parameter int NofBins = 1024,
    parameter int AccW    = 48
);
    localparam int IdxW = $clog2(NofBins);

    logic                      start_i;
    logic [15:0]               accum_num_i;
    logic signed [NofBits-1:0] fft_re_i;
    logic signed [NofBits-1:0] fft_im_i;
    logic [IdxW-1:0]           xk_index_i;
    logic                      dv_i;

    logic [AccW-1:0]           out_data_o;
    logic [IdxW-1:0]           out_index_o;
    logic                      out_valid_o;
    logic                      out_last_o;
    logic                      busy_o;
    logic                      done_o;
    logic                      overrun_o;
    logic [15:0]               frame_cnt_o;

    modport master (
        output start_i, accum_num_i, fft_re_i, fft_im_i, xk_index_i, dv_i,
        input  out_data_o, out_index_o, out_valid_o, out_last_o,
        input  busy_o, done_o, overrun_o, frame_cnt_o
    );

    modport slave (
        input  start_i, accum_num_i, fft_re_i, fft_im_i, xk_index_i, dv_i,
        output out_data_o, out_index_o, out_valid_o, out_last_o,
        output busy_o, done_o, overrun_o, frame_cnt_o
    );
endinterface

// File: rtl/power_spec_accum.sv
// power_spec_accum
//   Squares each complex FFT bin to power re^2+im^2 and accumulates it per
//   bin over a programmable number of frames in an on-chip RAM, then streams
//   the accumulated spectrum out bin by bin.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : power_spec_accum_if.slave (control, FFT stream, result stream, status)
module power_spec_accum #(
    parameter int NofBits = 16,
    parameter int NofBins = 1024,
    parameter int AccW    = 48
) (
    input  logic               clk,
    input  logic               rst,
    power_spec_accum_if.slave  bus
);
    localparam int IdxW = $clog2(NofBins);
    localparam int PowW = 2 * NofBits + 1;
    localparam logic [IdxW-1:0] LastBin = IdxW'(NofBins - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACCUM,
        FLUSH,
        DUMP
    } state_t;

    state_t state_q, state_d;

    logic [15:0]     accum_num_q;
    logic [1:0]      flush_cnt_q;
    logic [IdxW:0]   dump_cnt_q;

    logic            start_ok;
    logic            accept;
    logic            frame_end;
    logic            dump_issue;
    logic [IdxW-1:0] rd_addr;

    logic                      s1_vld;
    logic                      s1_first;
    logic signed [NofBits-1:0] s1_re;
    logic signed [NofBits-1:0] s1_im;
    logic [IdxW-1:0]           s1_idx;

    logic                      s2_vld;
    logic                      s2_first;
    logic [2*NofBits-1:0]      s2_rr;
    logic [2*NofBits-1:0]      s2_ii;
    logic [IdxW-1:0]           s2_idx;

    logic signed [2*NofBits-1:0] sq_re;
    logic signed [2*NofBits-1:0] sq_im;
    logic [PowW-1:0]             pow;
    logic [AccW-1:0]             pow_ext;
    logic [AccW-1:0]             wr_data;

    logic [AccW-1:0] ram [NofBins];
    logic [AccW-1:0] ram_rd_q;

    logic            dump_vld_q;
    logic [IdxW-1:0] dump_idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The single RAM read port serves the accumulate read-modify-write
    // (address from S1) except while dumping, when the dump counter owns it.
    always_comb begin
        state_d    = state_q;
        start_ok   = 1'b0;
        accept     = 1'b0;
        frame_end  = 1'b0;
        dump_issue = 1'b0;
        rd_addr    = s1_idx;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    start_ok = 1'b1;
                    state_d  = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (bus.dv_i && bus.xk_index_i == '0) begin
                    accept  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.dv_i) begin
                    accept = 1'b1;
                    if (bus.xk_index_i == LastBin) begin
                        frame_end = 1'b1;
                        if (bus.frame_cnt_o + 16'd1 == accum_num_q) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 2'd2) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                dump_issue = !dump_cnt_q[IdxW];
                rd_addr    = dump_cnt_q[IdxW-1:0];
                if (bus.out_valid_o && bus.out_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy and done track the FSM transitions so both change on the same
    // edge the FSM leaves or enters IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.frame_cnt_o <= '0;
            bus.overrun_o   <= 1'b0;
            accum_num_q     <= 16'd1;
            flush_cnt_q     <= '0;
            dump_cnt_q      <= '0;
        end else begin
            bus.busy_o  <= (state_d != IDLE);
            bus.done_o  <= (state_q == DUMP) && (state_d == IDLE);
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 2'd1 : 2'd0;
            if (state_q != DUMP) begin
                dump_cnt_q <= '0;
            end else if (dump_issue) begin
                dump_cnt_q <= dump_cnt_q + 1'b1;
            end
            if (start_ok) begin
                accum_num_q     <= (bus.accum_num_i == 16'd0) ? 16'd1 : bus.accum_num_i;
                bus.frame_cnt_o <= '0;
                bus.overrun_o   <= 1'b0;
            end else begin
                if (frame_end) begin
                    bus.frame_cnt_o <= bus.frame_cnt_o + 16'd1;
                end
                if (bus.dv_i && (state_q == FLUSH || state_q == DUMP)) begin
                    bus.overrun_o <= 1'b1;
                end
            end
        end
    end

    // Three-stage accumulate pipeline. The first-frame flag makes frame 0
    // overwrite each bin, so the RAM never needs clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_idx   <= '0;
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_idx   <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_first <= (bus.frame_cnt_o == 16'd0);
                s1_re    <= bus.fft_re_i;
                s1_im    <= bus.fft_im_i;
                s1_idx   <= bus.xk_index_i;
            end
            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_rr    <= sq_re;
            s2_ii    <= sq_im;
            s2_idx   <= s1_idx;
        end
    end

    // Squares are never negative, so they are carried as unsigned; the sum
    // needs one extra bit (max 2^31 for -32768,-32768).
    assign sq_re   = s1_re * s1_re;
    assign sq_im   = s1_im * s1_im;
    assign pow     = {1'b0, s2_rr} + {1'b0, s2_ii};
    assign pow_ext = {{(AccW - PowW){1'b0}}, pow};
    assign wr_data = s2_first ? pow_ext : ram_rd_q + pow_ext;

    // Accumulator RAM: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (s2_vld) begin
            ram[s2_idx] <= wr_data;
        end
        ram_rd_q <= ram[rd_addr];
    end

    // Dump path: read address registered alongside the RAM read, then one
    // output register, giving bin k on the outputs two cycles after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump_vld_q      <= 1'b0;
            dump_idx_q      <= '0;
            bus.out_valid_o <= 1'b0;
            bus.out_last_o  <= 1'b0;
            bus.out_data_o  <= '0;
            bus.out_index_o <= '0;
        end else begin
            dump_vld_q      <= dump_issue;
            dump_idx_q      <= dump_cnt_q[IdxW-1:0];
            bus.out_valid_o <= dump_vld_q;
            bus.out_last_o  <= dump_vld_q && (dump_idx_q == LastBin);
            if (dump_vld_q) begin
                bus.out_data_o  <= ram_rd_q;
                bus.out_index_o <= dump_idx_q;
            end
        end
    end
endmodule

// File: tb/tb_power_spec_accum.sv
// tb_power_spec_accum
//   Scoreboard bench for power_spec_accum built with 16 bins. Stimulus tasks
//   accumulate a per-bin power model; expected dump entries are queued when a
//   run's last frame is driven and popped by a monitor as outputs appear.
module tb_power_spec_accum;
    localparam int NB = 16;
    localparam int IW = 4;
    localparam int AW = 48;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [AW-1:0] data;
        logic          last;
    } exp_t;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    exp_t got;
    exp_t want;

    logic [AW-1:0]      model [NB];
    logic signed [15:0] fr_re [NB];
    logic signed [15:0] fr_im [NB];

    power_spec_accum_if #(.NofBits(16), .NofBins(NB), .AccW(AW)) bus ();

    power_spec_accum #(.NofBits(16), .NofBins(NB), .AccW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every dump beat is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.out_valid_o) begin
            total++;
            got = {bus.out_index_o, bus.out_data_o, bus.out_last_o};
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL dump_unexpected idx=%0d data=%0d last=%0b required=no output",
                         got.idx, got.data, got.last);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL dump_beat idx=%0d data=%0d last=%0b required idx=%0d data=%0d last=%0b",
                             got.idx, got.data, got.last, want.idx, want.data, want.last);
                end
            end
        end
    end

    task automatic start_run(input logic [15:0] num);
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.accum_num_i = num;
        for (int b = 0; b < NB; b++) model[b] = '0;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit counted);
        longint p;
        for (int b = 0; b < NB; b++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) begin
                    @(negedge clk);
                    bus.dv_i = 1'b0;
                end
            end
            @(negedge clk);
            bus.dv_i       = 1'b1;
            bus.fft_re_i   = fr_re[b];
            bus.fft_im_i   = fr_im[b];
            bus.xk_index_i = IW'(b);
            if (counted) begin
                p = longint'(fr_re[b]) * longint'(fr_re[b]) + longint'(fr_im[b]) * longint'(fr_im[b]);
                model[b] = model[b] + AW'(p);
            end
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.dv_i = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            e.idx  = IW'(b);
            e.data = model[b];
            e.last = (b == NB - 1);
            sb.push_back(e);
        end
    endtask

    task automatic fill_const(input logic signed [15:0] re, input logic signed [15:0] im);
        for (int b = 0; b < NB; b++) begin
            fr_re[b] = re;
            fr_im[b] = im;
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++) begin
            fr_re[b] = 16'($urandom());
            fr_im[b] = 16'($urandom());
        end
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy_done busy=%0b done=%0b required 0 0", bus.busy_o, bus.done_o);
        end
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.out_last_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valid_last valid=%0b last=%0b required 0 0", bus.out_valid_o, bus.out_last_o);
        end
        total++;
        if (bus.out_data_o !== '0 || bus.out_index_o !== '0) begin
            bad++;
            $display("[TB] FAIL reset_data data=%0d idx=%0d required 0 0", bus.out_data_o, bus.out_index_o);
        end
        total++;
        if (bus.frame_cnt_o !== 16'd0 || bus.overrun_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_status frame_cnt=%0d overrun=%0b required 0 0", bus.frame_cnt_o, bus.overrun_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit seen;
        start_run(16'd2);
        total++;
        if (bus.busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_busy_after_start busy=%0b required 1", bus.busy_o);
        end
        fill_const(16'sd3, 16'sd4);
        send_frame(1'b0, 1'b1);
        send_frame(1'b0, 1'b1);
        end_stream();
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_done seen=%0b required 1", seen);
        end
        total++;
        if (bus.busy_o !== 1'b0 || bus.frame_cnt_o !== 16'd2) begin
            bad++;
            $display("[TB] FAIL basic_end_status busy=%0b frame_cnt=%0d required 0 2", bus.busy_o, bus.frame_cnt_o);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL basic_all_bins left=%0d required 0", sb.size());
        end
        @(negedge clk);
        total++;
        if (bus.done_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_done_pulse done=%0b valid=%0b required 0 0", bus.done_o, bus.out_valid_o);
        end
    endtask

    task automatic test_accum_zero();
        bit seen;
        start_run(16'd0);
        for (int b = 0; b < NB; b++) begin
            fr_re[b] = 16'(b * 100);
            fr_im[b] = -16'(b * 37);
        end
        send_frame(1'b0, 1'b1);
        end_stream();
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || bus.frame_cnt_o !== 16'd1) begin
            bad++;
            $display("[TB] FAIL zero_as_one done=%0b frame_cnt=%0d required 1 1", seen, bus.frame_cnt_o);
        end
    endtask

    task automatic test_mid_start();
        bit seen;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            bus.dv_i        = 1'b1;
            bus.fft_re_i    = 16'sd1000;
            bus.fft_im_i    = -16'sd999;
            bus.xk_index_i  = IW'(b);
            bus.start_i     = (b == NB / 2);
            bus.accum_num_i = 16'd1;
        end
        total++;
        if (bus.busy_o !== 1'b1 || bus.frame_cnt_o !== 16'd0) begin
            bad++;
            $display("[TB] FAIL midstart_armed busy=%0b frame_cnt=%0d required 1 0", bus.busy_o, bus.frame_cnt_o);
        end
        for (int b = 0; b < NB; b++) model[b] = '0;
        fill_random();
        send_frame(1'b0, 1'b1);
        end_stream();
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || bus.frame_cnt_o !== 16'd1) begin
            bad++;
            $display("[TB] FAIL midstart_done done=%0b frame_cnt=%0d required 1 1", seen, bus.frame_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        start_run(16'd4);
        for (int f = 0; f < 4; f++) begin
            fill_random();
            send_frame(f >= 2, 1'b1);
        end
        end_stream();
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || bus.frame_cnt_o !== 16'd4) begin
            bad++;
            $display("[TB] FAIL b2b_done done=%0b frame_cnt=%0d required 1 4", seen, bus.frame_cnt_o);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_all_bins left=%0d required 0", sb.size());
        end
    endtask

    task automatic test_extreme();
        bit seen;
        start_run(16'd2000);
        fill_const(16'sd0, 16'sd0);
        fr_re[5] = -16'sd32768;
        fr_im[5] = -16'sd32768;
        for (int f = 0; f < 2000; f++) send_frame(1'b0, 1'b1);
        end_stream();
        total++;
        if (model[5] !== 48'd4294967296000) begin
            bad++;
            $display("[TB] FAIL extreme_model bin5=%0d required 4294967296000", model[5]);
        end
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || bus.frame_cnt_o !== 16'd2000) begin
            bad++;
            $display("[TB] FAIL extreme_done done=%0b frame_cnt=%0d required 1 2000", seen, bus.frame_cnt_o);
        end
    endtask

    task automatic test_overrun();
        bit seen;
        int c;
        start_run(16'd1);
        fill_random();
        send_frame(1'b0, 1'b1);
        end_stream();
        push_expected();
        c = 0;
        while (!bus.out_valid_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (bus.out_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_dump_start valid=%0b required 1", bus.out_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            bus.dv_i       = 1'b1;
            bus.fft_re_i   = 16'sd12345;
            bus.fft_im_i   = 16'sd321;
            bus.xk_index_i = IW'(k);
            @(negedge clk);
        end
        bus.dv_i = 1'b0;
        total++;
        if (bus.overrun_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_set overrun=%0b required 1", bus.overrun_o);
        end
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || bus.overrun_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_sticky done=%0b overrun=%0b required 1 1", seen, bus.overrun_o);
        end
        start_run(16'd1);
        total++;
        if (bus.overrun_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_clear overrun=%0b required 0", bus.overrun_o);
        end
        fill_const(-16'sd5, 16'sd12);
        send_frame(1'b1, 1'b1);
        end_stream();
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || bus.overrun_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_clean_run done=%0b overrun=%0b required 1 0", seen, bus.overrun_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int c;
        int n_valid;
        start_run(16'd3);
        fill_const(16'sd2, 16'sd2);
        send_frame(1'b0, 1'b1);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            bus.xk_index_i = IW'(b);
        end
        #2 rst = 1'b0;
        bus.dv_i = 1'b0;
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.frame_cnt_o !== 16'd0) begin
            bad++;
            $display("[TB] FAIL rst_accum busy=%0b frame_cnt=%0d required 0 0", bus.busy_o, bus.frame_cnt_o);
        end
        @(negedge clk);
        rst = 1'b1;

        start_run(16'd1);
        fill_const(16'sd7, -16'sd7);
        send_frame(1'b0, 1'b1);
        end_stream();
        push_expected();
        c = 0;
        n_valid = 0;
        while (n_valid < 4 && c < 100) begin
            @(negedge clk);
            if (bus.out_valid_o) n_valid++;
            c++;
        end
        total++;
        if (n_valid !== 4) begin
            bad++;
            $display("[TB] FAIL rst_dump_reached beats=%0d required 4", n_valid);
        end
        #2 rst = 1'b0;
        sb.delete();
        #1;
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== '0 || bus.out_index_o !== '0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_dump valid=%0b data=%0d idx=%0d busy=%0b required 0 0 0 0",
                     bus.out_valid_o, bus.out_data_o, bus.out_index_o, bus.busy_o);
        end
        @(negedge clk);
        rst = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid_o || bus.busy_o) n_valid++;
        end
        total++;
        if (n_valid !== 0) begin
            bad++;
            $display("[TB] FAIL rst_quiet active_cycles=%0d required 0", n_valid);
        end

        start_run(16'd1);
        fill_const(16'sd1, 16'sd0);
        send_frame(1'b0, 1'b1);
        end_stream();
        push_expected();
        wait_done(NB + 40, seen);
        total++;
        if (seen !== 1'b1 || sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL rst_fresh_run done=%0b left=%0d required 1 0", seen, sb.size());
        end
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.accum_num_i = 16'd0;
        bus.fft_re_i    = '0;
        bus.fft_im_i    = '0;
        bus.xk_index_i  = '0;
        bus.dv_i        = 1'b0;
        test_reset();
        test_basic();
        test_accum_zero();
        test_mid_start();
        test_back_to_back();
        test_extreme();
        test_overrun();
        test_reset_mid();
        repeat (5) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drained left=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
